// File: rtl/udp_rx_sequencer8.sv
// UDP receive sequencer: counts header bytes into an external decoder, filters on port/length,
// then frames or discards the payload. Define UDP_RX_STATS_EN to add accept/drop counters.
module udp_rx_sequencer8 #(
    parameter int unsigned AVL_SIZE    = 8,
    parameter int unsigned HDR_BYTES   = 8,
    parameter int unsigned MAX_PAYLOAD = 1472
) (
    input  logic                clk,
    input  logic                sync_reset,
    input  logic                data_in_valid,
    input  logic                data_in_sop,
    input  logic [AVL_SIZE-1:0] data_in,
    output logic                data_in_ready,
    output logic                hdr_shift_en,
    output logic [AVL_SIZE-1:0] hdr_data,
    input  logic [15:0]         dec_dst_port,
    input  logic [15:0]         dec_length,
    input  logic [15:0]         listen_port,
    output logic                payload_valid,
    output logic [AVL_SIZE-1:0] payload_data,
    output logic                payload_sop,
    output logic                payload_eop,
    output logic                payload_abort,
    output logic                pkt_accepted,
`ifdef UDP_RX_STATS_EN
    output logic [31:0]         rx_ok_cnt,
    output logic [31:0]         rx_drop_cnt,
`endif
    output logic                pkt_dropped
);

    localparam logic [3:0]  HdrLast = 4'(HDR_BYTES - 1);
    localparam logic [15:0] MaxPay  = 16'(MAX_PAYLOAD);

    typedef enum logic [2:0] {
        StIdle,
        StHeader,
        StCheck,
        StPayload,
        StDrop
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            hdr_cnt_q, hdr_cnt_d;
    logic [15:0]           pay_cnt_q, pay_cnt_d;
    logic                  first_q, first_d;
    logic                  pvalid_q, pvalid_d;
    logic [AVL_SIZE-1:0]   pdata_q, pdata_d;
    logic                  psop_q, psop_d;
    logic                  peop_q, peop_d;
    logic                  abort_q, abort_d;
    logic                  acc_q, acc_d;
    logic                  drop_q, drop_d;
    logic                  consume;
    logic                  restart;
    logic                  reject;

    assign data_in_ready = (state_q != StCheck);
    assign consume       = data_in_valid & data_in_ready;
    // A consumed sop is always header byte 0, whatever state we were in.
    assign restart       = consume & data_in_sop;
    assign hdr_shift_en  = consume & (data_in_sop | (state_q == StHeader));
    assign hdr_data      = data_in;
    assign reject        = (dec_dst_port != listen_port) || (dec_length > MaxPay);

    always_comb begin
        state_d   = state_q;
        hdr_cnt_d = hdr_cnt_q;
        pay_cnt_d = pay_cnt_q;
        first_d   = first_q;
        pvalid_d  = 1'b0;
        pdata_d   = pdata_q;
        psop_d    = 1'b0;
        peop_d    = 1'b0;
        abort_d   = 1'b0;
        acc_d     = 1'b0;
        drop_d    = 1'b0;

        if (restart) begin
            state_d   = StHeader;
            hdr_cnt_d = 4'd1;
            pay_cnt_d = 16'd0;
            first_d   = 1'b0;
            drop_d    = (state_q == StHeader) || (state_q == StPayload);
            abort_d   = (state_q == StPayload);
        end else begin
            case (state_q)
                StIdle: begin
                end
                StHeader: begin
                    if (consume) begin
                        hdr_cnt_d = hdr_cnt_q + 4'd1;
                        if (hdr_cnt_q == HdrLast) begin
                            state_d = StCheck;
                        end
                    end
                end
                StCheck: begin
                    hdr_cnt_d = 4'd0;
                    if (reject) begin
                        drop_d    = 1'b1;
                        pay_cnt_d = dec_length;
                        state_d   = (dec_length == 16'd0) ? StIdle : StDrop;
                    end else if (dec_length == 16'd0) begin
                        acc_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        acc_d     = 1'b1;
                        pay_cnt_d = dec_length;
                        first_d   = 1'b1;
                        state_d   = StPayload;
                    end
                end
                StPayload: begin
                    if (consume) begin
                        pvalid_d = 1'b1;
                        pdata_d  = data_in;
                        psop_d   = first_q;
                        peop_d   = (pay_cnt_q == 16'd1);
                        first_d  = 1'b0;
                        if (pay_cnt_q != 16'd0) begin
                            pay_cnt_d = pay_cnt_q - 16'd1;
                        end
                        if (pay_cnt_q <= 16'd1) begin
                            state_d = StIdle;
                        end
                    end
                end
                StDrop: begin
                    if (consume) begin
                        if (pay_cnt_q <= 16'd1) begin
                            pay_cnt_d = 16'd0;
                            state_d   = StIdle;
                        end else begin
                            pay_cnt_d = pay_cnt_q - 16'd1;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q   <= StIdle;
            hdr_cnt_q <= 4'd0;
            pay_cnt_q <= 16'd0;
            first_q   <= 1'b0;
            pvalid_q  <= 1'b0;
            pdata_q   <= '0;
            psop_q    <= 1'b0;
            peop_q    <= 1'b0;
            abort_q   <= 1'b0;
            acc_q     <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_cnt_q <= hdr_cnt_d;
            pay_cnt_q <= pay_cnt_d;
            first_q   <= first_d;
            pvalid_q  <= pvalid_d;
            pdata_q   <= pdata_d;
            psop_q    <= psop_d;
            peop_q    <= peop_d;
            abort_q   <= abort_d;
            acc_q     <= acc_d;
            drop_q    <= drop_d;
        end
    end

    // Status pulses are registered: they appear the cycle after the deciding edge.
    assign payload_valid = pvalid_q;
    assign payload_data  = pdata_q;
    assign payload_sop   = psop_q;
    assign payload_eop   = peop_q;
    assign payload_abort = abort_q;
    assign pkt_accepted  = acc_q;
    assign pkt_dropped   = drop_q;

`ifdef UDP_RX_STATS_EN
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            rx_ok_cnt   <= 32'd0;
            rx_drop_cnt <= 32'd0;
        end else begin
            if (acc_q && (rx_ok_cnt != 32'hFFFF_FFFF)) begin
                rx_ok_cnt <= rx_ok_cnt + 32'd1;
            end
            if (drop_q && (rx_drop_cnt != 32'hFFFF_FFFF)) begin
                rx_drop_cnt <= rx_drop_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_udp_rx_sequencer8.sv
// Scoreboard bench for udp_rx_sequencer8 with a behavioural UDP header decoder.
// Define UDP_RX_STATS_EN to also check the accept/drop counters.
module tb_udp_rx_sequencer8;

    logic        clk = 1'b0;
    logic        sync_reset;
    logic        data_in_valid;
    logic        data_in_sop;
    logic [7:0]  data_in;
    logic        data_in_ready;
    logic        hdr_shift_en;
    logic [7:0]  hdr_data;
    logic [15:0] dec_dst_port;
    logic [15:0] dec_length;
    logic [15:0] listen_port;
    logic        payload_valid;
    logic [7:0]  payload_data;
    logic        payload_sop;
    logic        payload_eop;
    logic        payload_abort;
    logic        pkt_accepted;
    logic        pkt_dropped;
`ifdef UDP_RX_STATS_EN
    logic [31:0] rx_ok_cnt;
    logic [31:0] rx_drop_cnt;
`endif

    udp_rx_sequencer8 dut (
        .clk           (clk),
        .sync_reset    (sync_reset),
        .data_in_valid (data_in_valid),
        .data_in_sop   (data_in_sop),
        .data_in       (data_in),
        .data_in_ready (data_in_ready),
        .hdr_shift_en  (hdr_shift_en),
        .hdr_data      (hdr_data),
        .dec_dst_port  (dec_dst_port),
        .dec_length    (dec_length),
        .listen_port   (listen_port),
        .payload_valid (payload_valid),
        .payload_data  (payload_data),
        .payload_sop   (payload_sop),
        .payload_eop   (payload_eop),
        .payload_abort (payload_abort),
        .pkt_accepted  (pkt_accepted),
`ifdef UDP_RX_STATS_EN
        .rx_ok_cnt     (rx_ok_cnt),
        .rx_drop_cnt   (rx_drop_cnt),
`endif
        .pkt_dropped   (pkt_dropped)
    );

    always #5 clk = ~clk;

    // Header decoder model: 8-byte shift register, first byte ends up in the top byte.
    logic [63:0] hdr_sr;
    always @(posedge clk) begin
        if (sync_reset) hdr_sr <= 64'd0;
        else if (hdr_shift_en) hdr_sr <= {hdr_sr[55:0], hdr_data};
    end
    assign dec_dst_port = hdr_sr[47:32];
    assign dec_length   = hdr_sr[31:16] - 16'd8;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        int         stamp;
    } beat_t;

    beat_t      exp_q[$];
    logic [2:0] exp_ev[$];   // {abort, dropped, accepted}
    int         checks = 0;
    int         errors = 0;
    int         n_acc  = 0;
    int         n_drop = 0;

    localparam logic [2:0] EvAcc   = 3'b001;
    localparam logic [2:0] EvDrop  = 3'b010;
    localparam logic [2:0] EvAbort = 3'b110;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic push_ev(input logic [2:0] e);
        exp_ev.push_back(e);
        if (e[0]) n_acc++;
        if (e[1]) n_drop++;
    endtask

    // Called #1 after a posedge; returns #1 after the consuming posedge.
    task automatic send(input logic [7:0] b, input logic sop, input bit is_pay,
                        input bit bsop, input bit beop);
        beat_t bt;
        int    waited;
        data_in_valid = 1'b1;
        data_in_sop   = sop;
        data_in       = b;
        waited        = 0;
        while (!data_in_ready && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (waited >= 20) chk("ready_timeout", 32'd0, 32'd1);
        if (is_pay) begin
            bt.d     = b;
            bt.sop   = bsop;
            bt.eop   = beop;
            bt.stamp = cyc + 1;
            exp_q.push_back(bt);
        end
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
        data_in_sop   = 1'b0;
    endtask

    task automatic pay(input logic [7:0] b, input bit bsop, input bit beop);
        send(b, 1'b0, 1'b1, bsop, beop);
    endtask

    task automatic raw(input logic [7:0] b);
        send(b, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Source port 1234, checksum 0.
    task automatic header(input logic [15:0] dst, input logic [15:0] ulen);
        send(8'h04, 1'b1, 1'b0, 1'b0, 1'b0);
        raw(8'hD2);
        raw(dst[15:8]);
        raw(dst[7:0]);
        raw(ulen[15:8]);
        raw(ulen[7:0]);
        raw(8'h00);
        raw(8'h00);
    endtask

    task automatic frame_ok4();
        push_ev(EvAcc);
        header(16'd5000, 16'h000C);
        pay(8'hAA, 1'b1, 1'b0);
        pay(8'hBB, 1'b0, 1'b0);
        pay(8'hCC, 1'b0, 1'b0);
        pay(8'hDD, 1'b0, 1'b1);
    endtask

    task automatic monitor();
        beat_t      b;
        logic [2:0] e;
        forever begin
            @(negedge clk);
            if (pkt_accepted || pkt_dropped || payload_abort) begin
                if (exp_ev.size() == 0) begin
                    chk("event_unexpected", {29'd0, payload_abort, pkt_dropped, pkt_accepted},
                        32'd0);
                end else begin
                    e = exp_ev.pop_front();
                    chk("event", {29'd0, payload_abort, pkt_dropped, pkt_accepted}, {29'd0, e});
                end
            end
            if (payload_valid) begin
                if (exp_q.size() == 0) begin
                    chk("beat_unexpected", {21'd0, payload_valid, payload_sop, payload_eop,
                        payload_data}, 32'd0);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat", {22'd0, payload_sop, payload_eop, payload_data},
                        {22'd0, b.sop, b.eop, b.d});
                    chk("beat_latency", cyc, b.stamp);
                end
            end
        end
    endtask

    initial begin
        sync_reset    = 1'b1;
        data_in_valid = 1'b0;
        data_in_sop   = 1'b0;
        data_in       = 8'h00;
        listen_port   = 16'd5000;
        repeat (3) @(posedge clk);
        #1;
        sync_reset = 1'b0;

        // Reset state
        data_in = 8'h5A;
        #1;
        chk("rst_ready", {31'd0, data_in_ready}, 32'd1);
        chk("rst_outputs", {27'd0, payload_valid, payload_sop, payload_eop, payload_abort,
            pkt_accepted}, 32'd0);
        chk("rst_dropped", {31'd0, pkt_dropped}, 32'd0);
        chk("rst_shift_en", {31'd0, hdr_shift_en}, 32'd0);
        chk("hdr_data_copy", {24'd0, hdr_data}, 32'h5A);
        @(posedge clk);
        #1;

        fork
            monitor();
        join_none

        // sync_reset mid-payload: no abort, no eop
        push_ev(EvAcc);
        header(16'd5000, 16'h000C);
        pay(8'hAA, 1'b1, 1'b0);
        pay(8'hBB, 1'b0, 1'b0);
        sync_reset = 1'b1;
        @(posedge clk);
        #1;
        sync_reset = 1'b0;
        chk("midrst_ready", {31'd0, data_in_ready}, 32'd1);
        chk("midrst_valid", {31'd0, payload_valid}, 32'd0);
        n_acc  = 0;
        n_drop = 0;
        repeat (2) @(posedge clk);
        #1;

        // Accepted 4-byte datagram
        frame_ok4();

        // Wrong port, then a normal frame
        listen_port = 16'd5001;
        push_ev(EvDrop);
        header(16'd5000, 16'h000C);
        raw(8'hAA); raw(8'hBB); raw(8'hCC); raw(8'hDD);
        listen_port = 16'd5000;
        frame_ok4();

        // Zero-length payload; trailing padding ignored in IDLE
        push_ev(EvAcc);
        header(16'd5000, 16'h0008);
        raw(8'h55); raw(8'h66);

        // Wrapped length (UDP length 4)
        push_ev(EvDrop);
        header(16'd5000, 16'h0004);
        raw(8'h01); raw(8'h02); raw(8'h03);

        // Oversize: 1500 bytes discarded, then padding, then a normal frame
        push_ev(EvDrop);
        header(16'd5000, 16'h05DC);
        for (int i = 0; i < 1500; i++) raw(8'(i));
        raw(8'h77); raw(8'h88);
        frame_ok4();

        // Restart mid-payload
        push_ev(EvAcc);
        header(16'd5000, 16'h000C);
        pay(8'hAA, 1'b1, 1'b0);
        pay(8'hBB, 1'b0, 1'b0);
        push_ev(EvAbort);
        push_ev(EvAcc);
        header(16'd5000, 16'h000A);
        pay(8'h11, 1'b1, 1'b0);
        pay(8'h22, 1'b0, 1'b1);

        // Restart mid-header
        send(8'h04, 1'b1, 1'b0, 1'b0, 1'b0);
        raw(8'hD2);
        raw(8'h13);
        push_ev(EvDrop);
        frame_ok4();

        // Gap of 3 cycles mid-payload
        push_ev(EvAcc);
        header(16'd5000, 16'h000C);
        pay(8'h31, 1'b1, 1'b0);
        pay(8'h32, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        pay(8'h33, 1'b0, 1'b0);
        pay(8'h34, 1'b0, 1'b1);

        repeat (5) @(posedge clk);
        #1;
        chk("events_drained", exp_ev.size(), 32'd0);
        chk("beats_drained", exp_q.size(), 32'd0);

`ifdef UDP_RX_STATS_EN
        chk("rx_ok_cnt", rx_ok_cnt, n_acc);
        chk("rx_drop_cnt", rx_drop_cnt, n_drop);
        sync_reset = 1'b1;
        @(posedge clk);
        #1;
        sync_reset = 1'b0;
        chk("rx_ok_cnt_rst", rx_ok_cnt, 32'd0);
        chk("rx_drop_cnt_rst", rx_drop_cnt, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
